// File: rtl/uart_ext_pkg.sv
// Shared constants, FSM state encoding and helpers for the uart_ext block.
package uart_ext_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_st_e;

  // Oversample divider; never below one clock per tick.
  function automatic int uart_div(input int freq_hz, input int baud);
    int d;
    d = freq_hz / (baud * 16);
    return (d < 1) ? 1 : d;
  endfunction

  // Parity bit for a zero-extended character.
  function automatic logic par_bit(input logic [7:0] d, input int mode);
    return (mode == PAR_ODD) ? ~(^d) : (^d);
  endfunction

endpackage

// File: rtl/uart_ext_if.sv
// Host-side and line-side signals of uart_ext; clock and reset stay outside.
interface uart_ext_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          uart_rxd;
  logic          uart_txd;
  logic [7:0]    tx_data;
  logic          tx_wr;
  logic          tx_busy;
  logic          tx_idle;
  logic [7:0]    rx_data;
  logic          rx_avail;
  logic          rx_ack;
  logic          rx_error;
  logic          rx_parity_err;
  logic          rx_overrun;
  logic          err_clr;
  logic [LW-1:0] tx_level;
  logic [LW-1:0] rx_level;

  modport slave (
    input  uart_rxd, tx_data, tx_wr, rx_ack, err_clr,
    output uart_txd, tx_busy, tx_idle, rx_data, rx_avail,
           rx_error, rx_parity_err, rx_overrun, tx_level, rx_level
  );

  modport master (
    output uart_rxd, tx_data, tx_wr, rx_ack, err_clr,
    input  uart_txd, tx_busy, tx_idle, rx_data, rx_avail,
           rx_error, rx_parity_err, rx_overrun, tx_level, rx_level
  );

endinterface

// File: rtl/uart_ext_fifo.sv
// Synchronous FIFO; a pop frees a slot for a push in the same cycle even when full.
module uart_ext_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      lvl_q;
  logic             do_push, do_pop;

  assign empty_o = (lvl_q == '0);
  assign full_o  = (lvl_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rp_q];
  assign level_o = lvl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= wdata_i;
        wp_q        <= wp_q + AW'(1);
      end
      if (do_pop) rp_q <= rp_q + AW'(1);
      if (do_push && !do_pop)      lvl_q <= lvl_q + (AW+1)'(1);
      else if (!do_push && do_pop) lvl_q <= lvl_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_ext.sv
// UART with TX/RX FIFOs, 16x oversampling, configurable framing and sticky error flags.
module uart_ext
  import uart_ext_pkg::*;
#(
  parameter int FREQ_HZ    = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic      clk,
  input  logic      reset,
  uart_ext_if.slave bus
);
  localparam int DIV = uart_div(FREQ_HZ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = 3;

  // ---------------- oversample tick ----------------
  logic [CW-1:0] div_q, div_d;
  logic          tick;

  always_comb begin
    tick  = (div_q == CW'(DIV - 1));
    div_d = tick ? '0 : div_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_q <= '0;
    else        div_q <= div_d;
  end

  // ---------------- TX path ----------------
  logic                 tx_pop, tx_full, tx_empty;
  logic [DATA_BITS-1:0] tx_head;
  uart_st_e             tx_st_q;
  logic [3:0]           tx_tcnt_q;
  logic [IW-1:0]        tx_idx_q;
  logic [DATA_BITS-1:0] tx_sh_q;
  logic                 tx_par_q, tx_txd_q;
  logic                 tx_end, tx_stop_last;

  uart_ext_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_txf (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (bus.tx_wr),
    .pop_i   (tx_pop),
    .wdata_i (bus.tx_data[DATA_BITS-1:0]),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .level_o (bus.tx_level)
  );

  assign tx_end       = (tx_tcnt_q == 4'hF);
  assign tx_stop_last = (tx_idx_q == IW'(STOP_BITS - 1));
  // Reloading straight out of the last stop bit keeps frames gap-free.
  assign tx_pop = tick && !tx_empty &&
                  ((tx_st_q == ST_IDLE) || (tx_st_q == ST_STOP && tx_end && tx_stop_last));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_st_q   <= ST_IDLE;
      tx_tcnt_q <= '0;
      tx_idx_q  <= '0;
      tx_sh_q   <= '0;
      tx_par_q  <= 1'b0;
      tx_txd_q  <= 1'b1;
    end else if (tick) begin
      tx_tcnt_q <= (tx_st_q == ST_IDLE) ? 4'd0 : tx_tcnt_q + 4'd1;
      unique case (tx_st_q)
        ST_IDLE: if (!tx_empty) begin
          tx_st_q  <= ST_START;
          tx_txd_q <= 1'b0;
          tx_sh_q  <= tx_head;
          tx_par_q <= par_bit(8'(tx_head), PARITY);
        end
        ST_START: if (tx_end) begin
          tx_st_q  <= ST_DATA;
          tx_txd_q <= tx_sh_q[0];
          tx_sh_q  <= tx_sh_q >> 1;
          tx_idx_q <= '0;
        end
        ST_DATA: if (tx_end) begin
          if (tx_idx_q == IW'(DATA_BITS - 1)) begin
            tx_idx_q <= '0;
            if (PARITY != PAR_NONE) begin
              tx_st_q  <= ST_PARITY;
              tx_txd_q <= tx_par_q;
            end else begin
              tx_st_q  <= ST_STOP;
              tx_txd_q <= 1'b1;
            end
          end else begin
            tx_idx_q <= tx_idx_q + IW'(1);
            tx_txd_q <= tx_sh_q[0];
            tx_sh_q  <= tx_sh_q >> 1;
          end
        end
        ST_PARITY: if (tx_end) begin
          tx_st_q  <= ST_STOP;
          tx_txd_q <= 1'b1;
        end
        ST_STOP: if (tx_end) begin
          if (!tx_stop_last) begin
            tx_idx_q <= tx_idx_q + IW'(1);
          end else if (!tx_empty) begin
            tx_st_q  <= ST_START;
            tx_idx_q <= '0;
            tx_txd_q <= 1'b0;
            tx_sh_q  <= tx_head;
            tx_par_q <= par_bit(8'(tx_head), PARITY);
          end else begin
            tx_st_q  <= ST_IDLE;
            tx_idx_q <= '0;
          end
        end
        default: tx_st_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.uart_txd = tx_txd_q;
  assign bus.tx_busy  = tx_full;
  assign bus.tx_idle  = tx_empty && (tx_st_q == ST_IDLE);

  // ---------------- RX path ----------------
  logic [1:0]           sync_q;
  logic                 rxs, rx_prev_q;
  uart_st_e             rx_st_q;
  logic [3:0]           rx_tcnt_q;
  logic [IW-1:0]        rx_idx_q;
  logic [DATA_BITS-1:0] rx_sh_q;
  logic                 rx_wait_q, rx_mid;
  logic                 rx_push, rx_full, rx_empty;
  logic                 ferr_set, perr_set, ovr_set;
  logic [DATA_BITS-1:0] rx_head;
  logic                 ferr_q, perr_q, ovr_q;

  assign rxs    = sync_q[1];
  assign rx_mid = tick && (rx_tcnt_q == 4'hF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], bus.uart_rxd};
      rx_prev_q <= rxs;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_st_q   <= ST_IDLE;
      rx_tcnt_q <= '0;
      rx_idx_q  <= '0;
      rx_sh_q   <= '0;
      rx_wait_q <= 1'b0;
    end else begin
      unique case (rx_st_q)
        ST_IDLE: if (rx_prev_q && !rxs) begin
          rx_st_q   <= ST_START;
          rx_tcnt_q <= '0;
        end
        // Start bit is checked at its midpoint; a high line there was a glitch.
        ST_START: if (tick) begin
          rx_tcnt_q <= rx_tcnt_q + 4'd1;
          if (rx_tcnt_q == 4'd7) begin
            rx_tcnt_q <= '0;
            rx_idx_q  <= '0;
            rx_st_q   <= rxs ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: if (tick) begin
          rx_tcnt_q <= rx_tcnt_q + 4'd1;
          if (rx_mid) begin
            rx_sh_q <= {rxs, rx_sh_q[DATA_BITS-1:1]};
            if (rx_idx_q == IW'(DATA_BITS - 1))
              rx_st_q <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            else
              rx_idx_q <= rx_idx_q + IW'(1);
          end
        end
        ST_PARITY: if (tick) begin
          rx_tcnt_q <= rx_tcnt_q + 4'd1;
          if (rx_mid) rx_st_q <= ST_STOP;
        end
        ST_STOP: begin
          if (rx_wait_q) begin
            if (rxs) begin
              rx_st_q   <= ST_IDLE;
              rx_wait_q <= 1'b0;
            end
          end else if (tick) begin
            rx_tcnt_q <= rx_tcnt_q + 4'd1;
            if (rx_mid) begin
              if (rxs) rx_st_q   <= ST_IDLE;
              else     rx_wait_q <= 1'b1;
            end
          end
        end
        default: rx_st_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_push  = (rx_st_q == ST_STOP) && !rx_wait_q && rx_mid && rxs;
    ferr_set = (rx_st_q == ST_STOP) && !rx_wait_q && rx_mid && !rxs;
    perr_set = (rx_st_q == ST_PARITY) && rx_mid && (rxs != par_bit(8'(rx_sh_q), PARITY));
    ovr_set  = rx_push && rx_full && !bus.rx_ack;
  end

  uart_ext_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rxf (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (rx_push),
    .pop_i   (bus.rx_ack),
    .wdata_i (rx_sh_q),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .level_o (bus.rx_level)
  );

  // A set in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ferr_q <= (ferr_q & ~bus.err_clr) | ferr_set;
      perr_q <= (perr_q & ~bus.err_clr) | perr_set;
      ovr_q  <= (ovr_q  & ~bus.err_clr) | ovr_set;
    end
  end

  assign bus.rx_data       = 8'(rx_head);
  assign bus.rx_avail      = !rx_empty;
  assign bus.rx_error      = ferr_q;
  assign bus.rx_parity_err = perr_q;
  assign bus.rx_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_ext.sv
// Directed bench: three uart_ext instances (8N1, 7E2 loopback, 8O1 with depth 4).
module tb_uart_ext;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_ext_if #(.FIFO_DEPTH(16)) ifA ();
  uart_ext_if #(.FIFO_DEPTH(16)) ifB ();
  uart_ext_if #(.FIFO_DEPTH(4))  ifC ();

  logic ser = 1'b1;
  int   sel = 0;
  assign ifA.uart_rxd = (sel == 0) ? ser : 1'b1;
  assign ifC.uart_rxd = (sel == 1) ? ser : 1'b1;
  assign ifB.uart_rxd = ifB.uart_txd;

  uart_ext #(.FREQ_HZ(50000000), .BAUD(3125000), .DATA_BITS(8), .PARITY(0),
             .STOP_BITS(1), .FIFO_DEPTH(16)) dutA (.clk(clk), .reset(rst_n), .bus(ifA));
  uart_ext #(.FREQ_HZ(50000000), .BAUD(3125000), .DATA_BITS(7), .PARITY(2),
             .STOP_BITS(2), .FIFO_DEPTH(16)) dutB (.clk(clk), .reset(rst_n), .bus(ifB));
  uart_ext #(.FREQ_HZ(50000000), .BAUD(3125000), .DATA_BITS(8), .PARITY(1),
             .STOP_BITS(1), .FIFO_DEPTH(4))  dutC (.clk(clk), .reset(rst_n), .bus(ifC));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tx_push(input int w, input logic [7:0] d);
    case (w)
      0: begin ifA.tx_data = d; ifA.tx_wr = 1'b1; end
      1: begin ifB.tx_data = d; ifB.tx_wr = 1'b1; end
      default: begin ifC.tx_data = d; ifC.tx_wr = 1'b1; end
    endcase
    @(negedge clk);
    ifA.tx_wr = 1'b0; ifB.tx_wr = 1'b0; ifC.tx_wr = 1'b0;
  endtask

  task automatic rx_pop(input int w);
    case (w)
      0: ifA.rx_ack = 1'b1;
      1: ifB.rx_ack = 1'b1;
      default: ifC.rx_ack = 1'b1;
    endcase
    @(negedge clk);
    ifA.rx_ack = 1'b0; ifB.rx_ack = 1'b0; ifC.rx_ack = 1'b0;
  endtask

  task automatic clr(input int w);
    case (w)
      0: ifA.err_clr = 1'b1;
      1: ifB.err_clr = 1'b1;
      default: ifC.err_clr = 1'b1;
    endcase
    @(negedge clk);
    ifA.err_clr = 1'b0; ifB.err_clr = 1'b0; ifC.err_clr = 1'b0;
  endtask

  // Serial 8-bit frame into instance A (s=0) or C (s=1); pm: 0 none, 1 odd, 2 even.
  task automatic send_frame(input int s, input logic [7:0] d, input int pm,
                            input logic flip, input logic stopv);
    logic p;
    p   = 1'b0;
    sel = s;
    ser = 1'b0; repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser = d[i]; p = p ^ d[i];
      repeat (16) @(negedge clk);
    end
    if (pm != 0) begin
      if (pm == 1) p = ~p;
      ser = p ^ flip; repeat (16) @(negedge clk);
    end
    ser = stopv; repeat (16) @(negedge clk);
    ser = 1'b1;  repeat (32) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] fr;
    logic [7:0] ov [5];
    logic       ok, s175;
    int         cnt;

    ifA.tx_data = '0; ifA.tx_wr = 0; ifA.rx_ack = 0; ifA.err_clr = 0;
    ifB.tx_data = '0; ifB.tx_wr = 0; ifB.rx_ack = 0; ifB.err_clr = 0;
    ifC.tx_data = '0; ifC.tx_wr = 0; ifC.rx_ack = 0; ifC.err_clr = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_txd",      ifA.uart_txd, 1);
    chk("rst_tx_idle",  ifA.tx_idle, 1);
    chk("rst_tx_busy",  ifA.tx_busy, 0);
    chk("rst_rx_avail", ifA.rx_avail, 0);
    chk("rst_tx_level", ifA.tx_level, 0);
    chk("rst_rx_level", ifA.rx_level, 0);
    chk("rst_rx_data",  ifA.rx_data, 0);
    chk("rst_flags",    {ifA.rx_error, ifA.rx_parity_err, ifA.rx_overrun}, 0);

    // 0xA5 in 8N1: start, LSB-first data, stop; each level 16 clocks
    fr = {1'b1, 8'hA5, 1'b0};
    tx_push(0, 8'hA5);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (ifA.uart_txd == 1'b0) ok = 1'b1;
      else @(negedge clk);
    end
    chk("a_start_seen", ok, 1);
    for (int b = 0; b < 10; b++) begin
      cnt = 0;
      for (int k = 0; k < 16; k++) begin
        if (ifA.uart_txd == fr[b]) cnt++;
        @(negedge clk);
      end
      chk($sformatf("a_bit%0d_clks", b), cnt, 16);
    end
    chk("a_idle_after", ifA.tx_idle, 1);

    // 7E2 loopback, back-to-back frames with no gap
    tx_push(1, 8'h41);
    tx_push(1, 8'h7F);
    chk("b_start_low", ifB.uart_txd, 0);
    chk("b_level_pushpop", ifB.tx_level, 1);
    s175 = 1'b0;
    for (int k = 1; k <= 176; k++) begin
      @(negedge clk);
      if (k == 175) s175 = ifB.uart_txd;
    end
    chk("b_stop2_end", s175, 1);
    chk("b_no_gap", ifB.uart_txd, 0);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (ifB.rx_level == 2) ok = 1'b1;
      else @(negedge clk);
    end
    chk("b_rx_two", ok, 1);
    chk("b_rx0", ifB.rx_data, 8'h41);
    rx_pop(1);
    chk("b_rx1", ifB.rx_data, 8'h7F);
    rx_pop(1);
    chk("b_rx_empty", ifB.rx_avail, 0);
    chk("b_flags", {ifB.rx_error, ifB.rx_parity_err, ifB.rx_overrun}, 0);
    repeat (40) @(negedge clk);
    chk("b_tx_idle", ifB.tx_idle, 1);

    // TX FIFO full: write while busy is dropped
    for (int i = 0; i < 5; i++) tx_push(2, 8'(8'h30 + i));
    chk("c_busy", ifC.tx_busy, 1);
    chk("c_level_full", ifC.tx_level, 4);
    tx_push(2, 8'hEE);
    chk("c_level_drop", ifC.tx_level, 4);

    // 8O1 bad parity: still pushed, flag sticky until err_clr
    send_frame(1, 8'h00, 1, 1'b1, 1'b1);
    chk("c_perr_set", ifC.rx_parity_err, 1);
    chk("c_perr_avail", ifC.rx_avail, 1);
    chk("c_perr_data", ifC.rx_data, 8'h00);
    chk("c_perr_ferr", ifC.rx_error, 0);
    clr(2);
    chk("c_perr_clr", ifC.rx_parity_err, 0);
    rx_pop(2);
    send_frame(1, 8'h5A, 1, 1'b0, 1'b1);
    chk("c_good_perr", ifC.rx_parity_err, 0);
    chk("c_good_data", ifC.rx_data, 8'h5A);
    rx_pop(2);
    chk("c_good_empty", ifC.rx_avail, 0);

    // Overrun with depth 4: fifth character dropped, first four kept
    ov = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 4; i++) send_frame(1, ov[i], 1, 1'b0, 1'b1);
    chk("c_ovr_lvl4", ifC.rx_level, 4);
    chk("c_ovr_pre", ifC.rx_overrun, 0);
    send_frame(1, ov[4], 1, 1'b0, 1'b1);
    chk("c_ovr_lvl", ifC.rx_level, 4);
    chk("c_ovr_set", ifC.rx_overrun, 1);
    chk("c_ovr_perr", ifC.rx_parity_err, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("c_ovr_pop%0d", i), ifC.rx_data, ov[i]);
      rx_pop(2);
    end
    chk("c_ovr_empty", ifC.rx_avail, 0);
    rx_pop(2);
    chk("c_ack_empty_lvl", ifC.rx_level, 0);
    chk("c_tx_drained", {ifC.tx_idle, 3'(ifC.tx_level)}, 4'b1000);

    // Framing error on A: char discarded; receiver recovers
    send_frame(0, 8'h3C, 0, 1'b0, 1'b0);
    chk("a_ferr_set", ifA.rx_error, 1);
    chk("a_ferr_avail", ifA.rx_avail, 0);
    clr(0);
    chk("a_ferr_clr", ifA.rx_error, 0);
    send_frame(0, 8'hC3, 0, 1'b0, 1'b1);
    chk("a_rx_data", ifA.rx_data, 8'hC3);
    chk("a_rx_lvl", ifA.rx_level, 1);

    // 4-clock glitch is rejected without an error
    sel = 0;
    ser = 1'b0; repeat (4) @(negedge clk);
    ser = 1'b1; repeat (40) @(negedge clk);
    chk("a_glitch_lvl", ifA.rx_level, 1);
    chk("a_glitch_ferr", ifA.rx_error, 0);

    // Reset mid-frame
    tx_push(0, 8'h00);
    tx_push(0, 8'h00);
    repeat (40) @(negedge clk);
    chk("a_pre_rst_txd", ifA.uart_txd, 0);
    chk("a_pre_rst_lvl", ifA.tx_level, 1);
    rst_n = 1'b0;
    #1;
    chk("a_rst_txd", ifA.uart_txd, 1);
    chk("a_rst_txlvl", ifA.tx_level, 0);
    chk("a_rst_rxlvl", ifA.rx_level, 0);
    chk("a_rst_rxdata", ifA.rx_data, 0);
    chk("a_rst_idle", ifA.tx_idle, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("a_post_rst_txd", ifA.uart_txd, 1);
    chk("a_post_rst_avail", ifA.rx_avail, 0);
    chk("a_post_rst_idle", ifA.tx_idle, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_ext.md
UART_EXT -- requirements
Module: uart_ext

Interface
REQ-001 Parameter FREQ_HZ, 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, 115200, line bit rate.
REQ-003 Parameter DATA_BITS, 8, character length; legal values 5..8.
REQ-004 Parameter PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, 1, stop bits; legal values 1 or 2.
REQ-006 Parameter FIFO_DEPTH, 16, entries per TX and RX FIFO; power of two, minimum 2.
REQ-007 Port clk in 1: the single clock.
REQ-008 Port reset in 1: asynchronous, active-low reset.
REQ-009 Port uart_rxd in 1: serial input, idle high.
REQ-010 Port uart_txd out 1: serial output, idle high.
REQ-011 Port tx_data in 8: character to send; bits above DATA_BITS ignored.
REQ-012 Port tx_wr in 1: one-cycle push of tx_data into the TX FIFO.
REQ-013 Port tx_busy out 1: TX FIFO full.
REQ-014 Port tx_idle out 1: TX FIFO empty and no frame in progress.
REQ-015 Port rx_data out 8: RX FIFO head, zero-extended above DATA_BITS.
REQ-016 Port rx_avail out 1: RX FIFO not empty.
REQ-017 Port rx_ack in 1: one-cycle pop of the RX FIFO head.
REQ-018 Port rx_error out 1: sticky framing error.
REQ-019 Port rx_parity_err out 1: sticky parity error.
REQ-020 Port rx_overrun out 1: sticky overrun.
REQ-021 Port err_clr in 1: clears all three sticky flags.
REQ-022 Port tx_level and rx_level out $clog2(FIFO_DEPTH)+1: FIFO fill counts.

Function
REQ-023 Oversample tick every DIV = max(1, FREQ_HZ/(BAUD*16)) clocks; a free-running counter wraps at DIV-1.
REQ-024 TX frame: start bit 0, DATA_BITS LSB first, optional parity bit, then STOP_BITS 1s; each bit lasts 16 ticks.
REQ-025 TX FSM states IDLE, START, DATA, PARITY, STOP; IDLE pops the FIFO when non-empty and enters START on the next tick boundary; PARITY is skipped when PARITY=0.
REQ-026 Back-to-back TX frames have no idle gap when the FIFO is non-empty at the end of STOP.
REQ-027 tx_wr while tx_busy drops the character; the FIFO and level are unchanged.
REQ-028 uart_rxd passes through a 2-flop synchroniser before use.
REQ-029 RX FSM states IDLE, START, DATA, PARITY, STOP; a falling edge in IDLE enters START.
REQ-030 START re-samples the line at tick 8; if high, return to IDLE (glitch rejection, no error).
REQ-031 DATA, PARITY and STOP each sample at mid-bit, i.e. every 16 ticks after the start mid-point.
REQ-032 Only the first stop bit is checked; a low sample sets rx_error, the character is discarded, and the FSM waits for the line to go high before IDLE.
REQ-033 Parity mismatch sets rx_parity_err; the character is still pushed.
REQ-034 A push into a full RX FIFO sets rx_overrun and discards the new character; stored data is preserved.
REQ-035 rx_ack while empty is ignored.
REQ-036 Simultaneous push and pop on the same FIFO in the same cycle both succeed, including when the FIFO is full; the level is unchanged.
REQ-037 A set event coinciding with err_clr leaves the flag set.
REQ-038 FIFO pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally; rx_data shows the head combinationally from the FIFO storage.

Reset
REQ-039 Reset low asynchronously forces both FSMs to IDLE, uart_txd=1, FIFOs empty (levels 0, tx_busy=0, tx_idle=1, rx_avail=0), all flags 0, rx_data=0, and the tick counter to 0.
REQ-040 Reset asserted mid-frame aborts the frame with no partial push; the synchroniser resets to 1.

Structure
REQ-041 Package uart_ext_pkg holds the parity mode constants, FSM state encodings and the DIV function.
REQ-042 One sub-module uart_ext_fifo (synchronous FIFO, parameterised width and depth) is instantiated twice, once for TX and once for RX.

Verification
REQ-043 Use FREQ_HZ=50000000 and BAUD=3125000 (DIV=1, bit time 16 clk); write 0xA5 with 8N1: uart_txd reads 0,1,0,1,0,0,1,0,1,1, with each level lasting 16 clk.
REQ-044 Loop uart_txd to uart_rxd with 7E2 and send 0x41,0x7F: rx_data reads 0x41, then 0x7F, and no flags are set.
REQ-045 Drive a frame with a bad parity bit (8O1, data 0x00, parity 0): rx_parity_err=1, rx_data=0x00; after err_clr the flag is 0.
REQ-046 Drive a frame with a stop bit of 0: rx_error=1 and rx_avail remains 0.
REQ-047 With FIFO_DEPTH=4, receive 5 characters without acking: rx_level=4, rx_overrun=1, and the pops return the first 4 characters.
REQ-048 Drive a 4-clk low glitch on uart_rxd, then assert reset mid-TX frame: nothing is received, uart_txd=1 immediately, and all levels are 0.
